// File: rtl/muldiv_iter_unit.sv
// Iterative multiply/divide/accumulate unit producing a 2W-bit HI/LO result.
// Optional MULDIV_EARLY_OUT_EN: finish early when |divisor| > |dividend|.
module muldiv_iter_unit #(
  parameter int DATA_WIDTH       = 32,
  parameter int MUL_CYCLES       = 2,
  parameter int DIV_BITS_PER_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [2:0]              req_op,
  input  logic [DATA_WIDTH-1:0]   reg0,
  input  logic [DATA_WIDTH-1:0]   reg1,
  input  logic [2*DATA_WIDTH-1:0] hilo_i,
  input  logic                    flush,
  output logic                    ready_o,
  output logic                    resp_valid,
  output logic [2*DATA_WIDTH-1:0] resp_hilo
);
  localparam int W  = DATA_WIDTH;
  localparam int B  = DIV_BITS_PER_CYC;
  localparam int N  = W / B;
  localparam int CW = $clog2(N + MUL_CYCLES + 1);
  localparam int MUL_LAST = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q, b_q;
  logic [W:0]      rem_q;
  logic [2*W-1:0]  hilo_q, res_q, out_q;
  logic            qneg_q, rneg_q;
  logic [CW-1:0]   cnt_q;

  logic            accept, div_in, sgn_in, a_neg, b_neg, div0, early;
  logic [W-1:0]    a_mag, b_mag;
  logic [2*W-1:0]  ea, eb, prod, mul_res, result;
  logic [W:0]      r_nx;
  logic [W-1:0]    q_nx, q_fin, r_fin;

  assign accept = req_valid & (state_q == S_IDLE) & ~flush;
  assign div_in = (req_op[2:1] == 2'b01);
  assign sgn_in = ~req_op[0];
  assign a_neg  = sgn_in & reg0[W-1];
  assign b_neg  = sgn_in & reg1[W-1];
  assign a_mag  = a_neg ? -reg0 : reg0;
  assign b_mag  = b_neg ? -reg1 : reg1;
  assign div0   = (reg1 == '0);
`ifdef MULDIV_EARLY_OUT_EN
  assign early  = (b_mag > a_mag);
`else
  assign early  = 1'b0;
`endif

  // Operands are sign/zero extended to 2W so one truncating product covers all ops.
  assign ea   = {{W{~op_q[0] & a_q[W-1]}}, a_q};
  assign eb   = {{W{~op_q[0] & b_q[W-1]}}, b_q};
  assign prod = ea * eb;

  always_comb begin
    mul_res = prod;
    unique case (1'b1)
      op_q[2:1] == 2'b10: mul_res = hilo_q + prod;
      op_q[2:1] == 2'b11: mul_res = hilo_q - prod;
      default:            mul_res = prod;
    endcase
  end

  // B restoring steps per cycle; a_q shifts out dividend bits and in quotient bits.
  always_comb begin
    r_nx = rem_q;
    q_nx = a_q;
    for (int i = 0; i < B; i++) begin
      r_nx = {r_nx[W-1:0], q_nx[W-1]};
      q_nx = {q_nx[W-2:0], 1'b0};
      if (r_nx >= {1'b0, b_q}) begin
        r_nx    = r_nx - {1'b0, b_q};
        q_nx[0] = 1'b1;
      end
    end
    q_fin = qneg_q ? -q_nx : q_nx;
    r_fin = rneg_q ? -r_nx[W-1:0] : r_nx[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (div_in)
            state_d = (div0 | early) ? S_DONE : S_DIV;
          else
            state_d = (MUL_CYCLES == 1) ? S_DONE : S_MUL;
        end
      end
      S_MUL: begin
        if (flush)
          state_d = S_IDLE;
        else if (cnt_q == CW'(MUL_LAST))
          state_d = S_DONE;
      end
      S_DIV: begin
        if (flush)
          state_d = S_IDLE;
        else if (cnt_q == CW'(N - 1))
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_o    = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE) & ~flush;
  assign result     = (op_q[2:1] == 2'b01) ? res_q : mul_res;
  assign resp_hilo  = resp_valid ? result : out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      hilo_q <= '0;
      res_q  <= '0;
      out_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        op_q   <= req_op;
        hilo_q <= hilo_i;
        cnt_q  <= '0;
        rem_q  <= '0;
        qneg_q <= a_neg ^ b_neg;
        rneg_q <= a_neg;
        if (div_in) begin
          a_q <= a_mag;
          b_q <= b_mag;
          if (div0)
            res_q <= {reg0, {W{1'b1}}};
          else if (early)
            res_q <= {reg0, {W{1'b0}}};
        end else begin
          a_q <= reg0;
          b_q <= reg1;
        end
      end
      if (state_q == S_MUL || state_q == S_DIV)
        cnt_q <= cnt_q + 1'b1;
      if (state_q == S_DIV) begin
        a_q   <= q_nx;
        rem_q <= r_nx;
        res_q <= {r_fin, q_fin};
      end
      if (resp_valid)
        out_q <= result;
    end
  end
endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised successor to the execute stage's multi-cycle path.
- Iterative multiply/divide/accumulate unit that updates the HI/LO pair, with configurable data width, multiplier latency and divider radix.
- Sits beside the ALU in EX: EX issues one request, stalls on ready_o, and takes the 2W-bit HI/LO result when resp_valid pulses.
- Supports a pipeline flush that aborts an in-flight operation.

Parameters:
- DATA_WIDTH, 32: operand width W; HI/LO result is 2W.
- MUL_CYCLES, 2: multiply latency in cycles, >=1.
- DIV_BITS_PER_CYC, 2: quotient bits retired per divide iteration; power of 2 that divides W. Iteration count N = W/DIV_BITS_PER_CYC.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- reg0  in  W  rs operand (dividend / multiplicand).
- reg1  in  W  rt operand (divisor / multiplier).
- hilo_i  in  2W  current HI/LO (HI = upper W bits), used by MADD*/MSUB*.
- flush  in  1  abort the current operation.
- ready_o  out  1  unit idle; a request can be accepted.
- resp_valid  out  1  one-cycle result strobe.
- resp_hilo  out  2W  result; HI = upper W bits.

Behaviour:
- One clock. Reset is asynchronous and active-high, applied on clk and rst.
- Reset state: IDLE; ready_o=1, resp_valid=0, resp_hilo=0; all internal counters and operand registers cleared.
- Reset asserted mid-operation discards all state immediately.

States and transitions:
- States: IDLE, MUL, DIV, DONE.
- ready_o = (state==IDLE).
- Accept occurs when req_valid & ready_o & ~flush. At accept, operands, op and hilo_i are latched; later changes to the inputs are ignored.
- IDLE -> MUL for ops 0,1,4..7.
- IDLE -> DIV for ops 2,3.
- MUL: counter runs MUL_CYCLES-1 cycles, then -> DONE. resp_valid rises MUL_CYCLES cycles after accept (accept = cycle 0).
- DIV: the accept cycle computes magnitudes and zero-checks the divisor. Cycles 1..N each retire DIV_BITS_PER_CYC bits (restoring radix-2^B). Then -> DONE, so resp_valid is at cycle N+1.
- DONE: resp_valid=1 for exactly one cycle and resp_hilo is updated that cycle; -> IDLE.
- resp_hilo holds its value until the next DONE.
- Back-to-back: a new request may be accepted in the cycle after DONE.

Arithmetic:
- Signed ops sign-extend to 2W; unsigned ops zero-extend.
- MADD*: hilo_i + product. MSUB*: hilo_i - product. Both wrap modulo 2^(2W).
- DIV*: LO = quotient, HI = remainder.
- Signed divide: quotient sign = sign(reg0) XOR sign(reg1); remainder takes the sign of reg0.
- -2^(W-1) / -1 gives LO = 0x80000000, HI = 0 (wrap, no exception).
- Divide by zero: DIV -> DONE at cycle 1, with HI = reg0 and LO = all ones, for both DIV and DIVU.

Flush:
- flush in any non-IDLE state -> IDLE next cycle. No resp_valid, and resp_hilo is unchanged.
- flush in DONE suppresses that cycle's resp_valid.
- flush together with req_valid in IDLE: no accept.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- With the macro defined, in the DIV accept cycle, if |divisor| > |dividend| (magnitudes, nonzero divisor): DIV -> DONE at cycle 1 with LO = 0 and HI = the original reg0.
- Without the macro, every nonzero divide takes N+1 cycles.

Test Plan:
- MULT reg0=0xFFFFFFFF, reg1=2 -> cycle 2: resp_hilo=0xFFFFFFFF_FFFFFFFE. Same operands with MULTU -> 0x00000001_FFFFFFFE.
- DIV reg0=0xFFFFFFF9 (-7), reg1=2 -> cycle 17 (W=32, B=2): LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MADDU hilo_i=0x00000000_FFFFFFFF, 1x1 -> 0x00000001_00000000. MSUBU hilo_i=0, 1x1 -> 0xFFFFFFFF_FFFFFFFF.
- DIVU reg0=5, reg1=0 -> cycle 1 resp_valid with HI=5, LO=0xFFFFFFFF.
- DIV accepted, flush at cycle 5 -> no resp_valid, ready_o=1 at cycle 6; MULTU 3x4 accepted at cycle 6 -> resp_hilo=12 at cycle 8. rst pulsed mid-divide -> outputs return to reset values immediately.
- DIVU 3/10 -> with MULDIV_EARLY_OUT_EN: cycle 1, LO=0, HI=3. Without the macro: cycle 17, same values.
